// File: rtl/axi_sram_slave_if.sv
// Shared-address-channel AXI bus between one master and the SRAM responder.
// The read/write direction rides on the address channel; there is no write-response channel.
interface axi_sram_slave_if;
  logic [5:0]  aid;
  logic [31:0] aaddr;
  logic        avalid;
  logic        awrite;
  logic [3:0]  alen;
  logic [1:0]  asize;
  logic [1:0]  aburst;
  logic        aready;
  logic [5:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [5:0]  rid;
  logic [63:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        proto_err;

  modport master (
    output aid, aaddr, avalid, awrite, alen, asize, aburst,
    output wid, wdata, wstrb, wlast, wvalid, rready,
    input  aready, wready, rid, rdata, rlast, rvalid, proto_err
  );

  modport slave (
    input  aid, aaddr, avalid, awrite, alen, asize, aburst,
    input  wid, wdata, wstrb, wlast, wvalid, rready,
    output aready, wready, rid, rdata, rlast, rvalid, proto_err
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI responder backed by a register-array RAM of 64-bit words.
// Serves one burst at a time; reads run at one beat per cycle, writes honour byte strobes.
module axi_sram_slave #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  axi_sram_slave_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t      state_q, state_d;
  logic        aready_q, aready_d;
  logic        wready_q, wready_d;
  logic        perr_q, perr_d;

  logic [5:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  cnt_q;
  logic [1:0]  size_q;
  logic [1:0]  burst_q;

  logic        rvalid_q;
  logic        rlast_q;
  logic [5:0]  rid_q;
  logic [63:0] rdata_q;

  logic [63:0] mem [MEM_DEPTH];

  logic        a_hs, w_hs, r_hs;
  logic        last_beat;
  logic        wrap_ok, bad_burst;
  logic [1:0]  eff_burst;
  logic [31:0] addr_nx;

  function automatic logic [IDX_W-1:0] widx(input logic [31:0] a);
    return a[IDX_W+2:3];
  endfunction

  // FIXED holds the address, WRAP folds inside an aligned (alen+1)<<asize window, else INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  bt,
                                            input logic [3:0]  ln);
    logic [31:0] step;
    logic [31:0] bound;
    logic [31:0] inc;
    step  = 32'd1 << sz;
    bound = ({28'd0, ln} + 32'd1) << sz;
    inc   = a + step;
    case (bt)
      2'b00:   return a;
      2'b10:   return (a & ~(bound - 32'd1)) | (inc & (bound - 32'd1));
      default: return inc;
    endcase
  endfunction

  assign a_hs      = bus.avalid & aready_q;
  assign w_hs      = bus.wvalid & wready_q;
  assign r_hs      = rvalid_q & bus.rready;
  assign last_beat = (cnt_q == len_q);

  assign wrap_ok   = (bus.alen == 4'd1) | (bus.alen == 4'd3) |
                     (bus.alen == 4'd7) | (bus.alen == 4'd15);
  assign bad_burst = (bus.aburst == 2'b11) | ((bus.aburst == 2'b10) & ~wrap_ok);
  assign eff_burst = bad_burst ? 2'b01 : bus.aburst;
  assign addr_nx   = next_addr(addr_q, size_q, burst_q, len_q);

  // ---- FSM state register and registered handshake outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      aready_q <= 1'b0;
      wready_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aready_q <= aready_d;
      wready_q <= wready_d;
      perr_q   <= perr_d;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_hs) state_d = bus.awrite ? WRITE : READ;
      WRITE:   if (w_hs && last_beat) state_d = IDLE;
      READ:    if (r_hs && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM outputs (next values of the registered handshakes) ----
  always_comb begin
    aready_d = (state_d == IDLE);
    wready_d = (state_d == WRITE);
    perr_d   = (a_hs & bad_burst) |
               (w_hs & ((bus.wlast != last_beat) | (bus.wid != id_q)));
  end

  // ---- burst tracking and read data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else if (a_hs) begin
      id_q    <= bus.aid;
      addr_q  <= bus.aaddr;
      len_q   <= bus.alen;
      size_q  <= bus.asize;
      burst_q <= eff_burst;
      cnt_q   <= '0;
      if (!bus.awrite) begin
        rdata_q  <= mem[widx(bus.aaddr)];
        rvalid_q <= 1'b1;
        rlast_q  <= (bus.alen == 4'd0);
        rid_q    <= bus.aid;
      end
    end else if (w_hs) begin
      addr_q <= addr_nx;
      cnt_q  <= cnt_q + 4'd1;
    end else if (r_hs) begin
      if (last_beat) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        addr_q  <= addr_nx;
        cnt_q   <= cnt_q + 4'd1;
        rdata_q <= mem[widx(addr_nx)];
        rlast_q <= ((cnt_q + 4'd1) == len_q);
      end
    end
  end

  // ---- RAM write port; contents survive reset ----
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wstrb[b]) mem[widx(addr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.aready    = aready_q;
  assign bus.wready    = wready_q;
  assign bus.proto_err = perr_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rlast     = rlast_q;
  assign bus.rid       = rid_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus hand-written burst sequences.
module tb_axi_sram_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if bus();

  axi_sram_slave #(.MEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  int nvec  = 0;
  int nfail = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic        wl [16];
  logic [5:0]  wi [16];
  logic        werr [16];
  logic [63:0] rd [16];
  logic        rl [16];
  logic [5:0]  ri [16];
  int          rcyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic wr, input logic [31:0] addr,
                     input logic [1:0] burst, input logic [7:0] strb,
                     input logic [63:0] data, input logic exp_err);
    vec_t v;
    v.nm = nm; v.wr = wr; v.addr = addr; v.burst = burst;
    v.strb = strb; v.data = data; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  task automatic set_wr(input int k, input logic [63:0] d, input logic [7:0] s,
                        input logic l, input logic [5:0] id);
    wd[k] = d; ws[k] = s; wl[k] = l; wi[k] = id;
  endtask

  task automatic idle_bus();
    bus.aid = '0; bus.aaddr = '0; bus.avalid = 1'b0; bus.awrite = 1'b0;
    bus.alen = '0; bus.asize = '0; bus.aburst = '0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic addr_phase(input logic w, input logic [5:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] size,
                            input logic [1:0] burst, output logic err);
    int n;
    n = 0;
    bus.avalid = 1'b1; bus.awrite = w; bus.aid = id; bus.aaddr = addr;
    bus.alen = len; bus.asize = size; bus.aburst = burst;
    while (!bus.aready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("aready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.avalid = 1'b0;
    err = bus.proto_err;
  endtask

  task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] size, input logic [1:0] burst, output logic aerr);
    int n;
    addr_phase(1'b1, id, addr, len, size, burst, aerr);
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      bus.wvalid = 1'b1; bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = wl[k]; bus.wid = wi[k];
      while (!bus.wready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("wready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      werr[k] = bus.proto_err;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input logic [1:0] burst, input logic stall,
                            output logic aerr);
    logic [63:0] hd;
    logic        hl;
    logic        held;
    int          beat, cyc;
    addr_phase(1'b0, id, addr, len, size, burst, aerr);
    chk("rd_first_valid", bus.rvalid, 1'b1);
    beat = 0; cyc = 0; held = 1'b0; hd = '0; hl = 1'b0;
    while (beat <= int'(len) && cyc < 200) begin
      bus.rready = stall ? (cyc % 3 == 0) : 1'b1;
      if (bus.rvalid && bus.rready) begin
        rd[beat] = bus.rdata; rl[beat] = bus.rlast; ri[beat] = bus.rid;
        beat++;
      end else if (bus.rvalid) begin
        hd = bus.rdata; hl = bus.rlast; held = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (held) begin
        chk($sformatf("rd_hold_data_b%0d", beat), bus.rdata, hd);
        chk($sformatf("rd_hold_last_b%0d", beat), bus.rlast, hl);
        chk($sformatf("rd_hold_valid_b%0d", beat), bus.rvalid, 1'b1);
        held = 1'b0;
      end
    end
    bus.rready = 1'b0;
    rcyc = cyc;
    if (beat <= int'(len)) chk("rd_beats_timeout", 64'(beat), 64'(int'(len) + 1));
    chk("rd_end_valid", bus.rvalid, 1'b0);
    chk("rd_end_last", bus.rlast, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic aerr;
    logic [63:0] exp_wrap [4];

    idle_bus();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_aready", bus.aready, 1'b0);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rlast", bus.rlast, 1'b0);
    chk("rst_perr", bus.proto_err, 1'b0);
    chk("rst_rid", bus.rid, 6'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    reset = 1'b0;
    chk("rel_aready_now", bus.aready, 1'b0);
    @(posedge clk); #1;
    chk("rel_aready_next", bus.aready, 1'b1);

    // Single-beat table (asize=3, alen=0)
    add("w200",      1, 32'h200,      2'b01, 8'hFF, 64'h0123456789ABCDEF, 0);
    add("w208",      1, 32'h208,      2'b01, 8'hFF, 64'hFEDCBA9876543210, 0);
    add("r200",      0, 32'h200,      2'b01, 8'h00, 64'h0123456789ABCDEF, 0);
    add("r208",      0, 32'h208,      2'b01, 8'h00, 64'hFEDCBA9876543210, 0);
    add("w300",      1, 32'h300,      2'b01, 8'hFF, 64'h1111111122222222, 0);
    add("w300_hi",   1, 32'h300,      2'b01, 8'hF0, 64'hAAAAAAAABBBBBBBB, 0);
    add("r300_hi",   0, 32'h300,      2'b01, 8'h00, 64'hAAAAAAAA22222222, 0);
    add("w7f8",      1, 32'h7F8,      2'b00, 8'hFF, 64'h5555AAAA5555AAAA, 0);
    add("rff8_alias",0, 32'hFF8,      2'b01, 8'h00, 64'h5555AAAA5555AAAA, 0);
    add("rhi_alias", 0, 32'h800007F8, 2'b01, 8'h00, 64'h5555AAAA5555AAAA, 0);
    add("r204_unal", 0, 32'h204,      2'b01, 8'h00, 64'h0123456789ABCDEF, 0);
    add("r208_rsv",  0, 32'h208,      2'b11, 8'h00, 64'hFEDCBA9876543210, 1);
    add("r200_wrap0",0, 32'h200,      2'b10, 8'h00, 64'h0123456789ABCDEF, 1);
    add("w310_rsv",  1, 32'h310,      2'b11, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 1);
    add("r310",      0, 32'h310,      2'b01, 8'h00, 64'h0F0F0F0F0F0F0F0F, 0);
    add("w300_edge", 1, 32'h300,      2'b01, 8'h81, 64'h99000000000000CC, 0);
    add("r300_edge", 0, 32'h300,      2'b01, 8'h00, 64'h99AAAAAA222222CC, 0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        set_wr(0, tbl[i].data, tbl[i].strb, 1'b1, 6'd1);
        write_burst(6'd1, tbl[i].addr, 4'd0, 2'd3, tbl[i].burst, aerr);
        chk({tbl[i].nm, "_aerr"}, aerr, tbl[i].exp_err);
        chk({tbl[i].nm, "_werr"}, werr[0], 1'b0);
      end else begin
        read_burst(6'd2, tbl[i].addr, 4'd0, 2'd3, tbl[i].burst, 1'b0, aerr);
        chk({tbl[i].nm, "_aerr"}, aerr, tbl[i].exp_err);
        chk({tbl[i].nm, "_data"}, rd[0], tbl[i].data);
        chk({tbl[i].nm, "_last"}, rl[0], 1'b1);
        chk({tbl[i].nm, "_rid"}, ri[0], 6'd2);
      end
    end

    // INCR write then read back at 0x100
    for (int k = 0; k < 4; k++) set_wr(k, 64'h11 * (k + 1), 8'hFF, (k == 3), 6'd5);
    write_burst(6'd5, 32'h100, 4'd3, 2'd3, 2'b01, aerr);
    chk("t1_w_aerr", aerr, 1'b0);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_werr%0d", k), werr[k], 1'b0);
    chk("t1_wready_end", bus.wready, 1'b0);
    chk("t1_aready_end", bus.aready, 1'b1);
    read_burst(6'd5, 32'h100, 4'd3, 2'd3, 2'b01, 1'b0, aerr);
    chk("t1_r_aerr", aerr, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_rdata%0d", k), rd[k], 64'h11 * (k + 1));
      chk($sformatf("t1_rlast%0d", k), rl[k], (k == 3));
      chk($sformatf("t1_rid%0d", k), ri[k], 6'd5);
    end
    chk("t1_rcycles", 64'(rcyc), 64'd4);

    // WRAP read starting mid-window
    exp_wrap[0] = 64'h44; exp_wrap[1] = 64'h11; exp_wrap[2] = 64'h22; exp_wrap[3] = 64'h33;
    read_burst(6'd3, 32'h118, 4'd3, 2'd3, 2'b10, 1'b0, aerr);
    chk("t2_aerr", aerr, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_rdata%0d", k), rd[k], exp_wrap[k]);
      chk($sformatf("t2_rlast%0d", k), rl[k], (k == 3));
    end

    // FIXED byte-size write into one word
    set_wr(0, 64'hAA, 8'h01, 1'b0, 6'd9);
    set_wr(1, 64'hBB00, 8'h02, 1'b1, 6'd9);
    write_burst(6'd9, 32'h200, 4'd1, 2'd0, 2'b00, aerr);
    chk("t3_aerr", aerr, 1'b0);
    chk("t3_werr0", werr[0], 1'b0);
    chk("t3_werr1", werr[1], 1'b0);
    read_burst(6'd9, 32'h200, 4'd1, 2'd3, 2'b01, 1'b0, aerr);
    chk("t3_w200", rd[0], 64'h0123456789ABBBAA);
    chk("t3_w208", rd[1], 64'hFEDCBA9876543210);

    // Early wlast with matching wid: errors on beats 1 and 3 only
    for (int k = 0; k < 4; k++) set_wr(k, 64'hD0 + k, 8'hFF, (k == 1), 6'd7);
    write_burst(6'd7, 32'h120, 4'd3, 2'd3, 2'b01, aerr);
    chk("t5a_aerr", aerr, 1'b0);
    for (int k = 0; k < 4; k++) chk($sformatf("t5a_werr%0d", k), werr[k], (k == 1 || k == 3));

    // Early wlast and wrong wid: error on every beat, data still written
    for (int k = 0; k < 4; k++) set_wr(k, 64'h55 + 64'h11 * k, 8'hFF, (k == 1), 6'd8);
    write_burst(6'd7, 32'h120, 4'd3, 2'd3, 2'b01, aerr);
    for (int k = 0; k < 4; k++) chk($sformatf("t5b_werr%0d", k), werr[k], 1'b1);
    @(posedge clk); #1;
    chk("t5b_perr_pulse_end", bus.proto_err, 1'b0);

    // 8-beat read with rready stalls
    read_burst(6'd4, 32'h100, 4'd7, 2'd3, 2'b01, 1'b1, aerr);
    chk("t4_aerr", aerr, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_rdata%0d", k), rd[k], 64'h11 * (k + 1));
      chk($sformatf("t4_rlast%0d", k), rl[k], (k == 7));
      chk($sformatf("t4_rid%0d", k), ri[k], 6'd4);
    end
    chk("t4_aready_after", bus.aready, 1'b1);

    // Reset during beat 2 of an 8-beat write
    for (int k = 0; k < 8; k++) set_wr(k, 64'hA0 + k, 8'hFF, (k == 7), 6'd1);
    write_burst(6'd1, 32'h400, 4'd7, 2'd3, 2'b01, aerr);
    addr_phase(1'b1, 6'd2, 32'h400, 4'd7, 2'd3, 2'b01, aerr);
    for (int k = 0; k < 2; k++) begin
      bus.wvalid = 1'b1; bus.wdata = 64'hB0 + k; bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wid = 6'd2;
      chk($sformatf("t6_wready_b%0d", k), bus.wready, 1'b1);
      @(posedge clk); #1;
    end
    bus.wdata = 64'hB2;
    #1 reset = 1'b1;
    #1;
    chk("t6_wready_rst", bus.wready, 1'b0);
    chk("t6_aready_rst", bus.aready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_wready_rst2", bus.wready, 1'b0);
    chk("t6_aready_rst2", bus.aready, 1'b0);
    bus.wvalid = 1'b0;
    reset = 1'b0;
    chk("t6_aready_rel", bus.aready, 1'b0);
    @(posedge clk); #1;
    chk("t6_aready_rel_next", bus.aready, 1'b1);
    read_burst(6'd6, 32'h400, 4'd7, 2'd3, 2'b01, 1'b0, aerr);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t6_rdata%0d", k), rd[k], (k < 2) ? 64'hB0 + k : 64'hA0 + k);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
